// File: rtl/mp3_ctrl_if.sv
// rtl/mp3_ctrl_if.sv - button/mp3-block signal bundle for the playback controller
//
// Purpose: groups the raw button inputs, the mp3 finish flag and the
// control outputs driven to the mp3 streaming block.
// Ports (signals):
//   i_btn_next/prev/pause/vol_up/vol_down  raw push-buttons, async, active-high
//   i_finish_song                          mp3 end-of-song level (other domain)
//   o_song_select[2:0]                     song index to mp3 block
//   o_pause                                pause level to mp3 block
//   o_vol[15:0]                            {att,att} volume word, 0 = loudest
//   o_busy                                 high while song-change hold-off runs
//   o_song_change                          one-cycle pulse per song change
// modport slave is the controller side, master is the driving side.

interface mp3_ctrl_if;
    logic       i_btn_next;
    logic       i_btn_prev;
    logic       i_btn_pause;
    logic       i_btn_vol_up;
    logic       i_btn_vol_down;
    logic       i_finish_song;
    logic [2:0] o_song_select;
    logic       o_pause;
    logic [15:0] o_vol;
    logic       o_busy;
    logic       o_song_change;

    modport master (
        output i_btn_next, i_btn_prev, i_btn_pause, i_btn_vol_up, i_btn_vol_down,
        output i_finish_song,
        input  o_song_select, o_pause, o_vol, o_busy, o_song_change
    );

    modport slave (
        input  i_btn_next, i_btn_prev, i_btn_pause, i_btn_vol_up, i_btn_vol_down,
        input  i_finish_song,
        output o_song_select, o_pause, o_vol, o_busy, o_song_change
    );
endinterface

// File: rtl/mp3_ctrl.sv
// rtl/mp3_ctrl.sv - playback controller: button debounce, song select, pause, volume
//
// Purpose: conditions five push-buttons and the mp3 finish flag, steps the
// song index (with a hold-off window after each change so the slow mp3 block
// can restart), toggles pause and steps a saturating attenuation value.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  mp3_ctrl_if.slave: raw buttons + finish flag in, mp3 controls out

module mp3_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 4000000,
    parameter int unsigned SONG_NUM        = 4,
    parameter logic [7:0]  VOL_INIT        = 8'h20,
    parameter logic [7:0]  VOL_STEP        = 8'h10,
    parameter logic [7:0]  VOL_MAX_ATT     = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    mp3_ctrl_if.slave  bus
);
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]        SEL_LAST  = 3'(SONG_NUM - 1);

    // Bit positions inside the conditioned input vectors.
    localparam int B_NEXT  = 0;
    localparam int B_PREV  = 1;
    localparam int B_PAUSE = 2;
    localparam int B_UP    = 3;
    localparam int B_DOWN  = 4;
    localparam int B_FIN   = 5;

    typedef enum logic [0:0] {ST_IDLE, ST_HOLD} state_t;

    logic [5:0]             raw_in;
    logic [5:0]             sync1_q, sync2_q;
    logic [4:0]             deb_q, deb_d, deb_prev_q;
    logic [4:0][DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic                   fin_prev_q;
    logic [4:0]             press;
    logic                   finish_ev;

    state_t                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [2:0]             sel_q, sel_d;
    logic                   pause_q, pause_d;
    logic [7:0]             att_q, att_d;
    logic                   song_change_q, song_change_d;

    logic                   change;
    logic [8:0]             att9, step9, dn_lim9, att_dec9, att_inc9;

    assign raw_in = {bus.i_finish_song, bus.i_btn_vol_down, bus.i_btn_vol_up,
                     bus.i_btn_pause, bus.i_btn_prev, bus.i_btn_next};

    assign press     = deb_q & ~deb_prev_q;
    assign finish_ev = sync2_q[B_FIN] & ~fin_prev_q;

    // Debounce: the level only follows the synced input after it has
    // differed continuously for DEBOUNCE_CYCLES cycles.
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                deb_d[i]    = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        sel_d         = sel_q;
        pause_d       = pause_q;
        att_d         = att_q;
        song_change_d = 1'b0;
        change        = 1'b0;

        att9     = {1'b0, att_q};
        step9    = {1'b0, VOL_STEP};
        dn_lim9  = {1'b0, VOL_MAX_ATT} - step9;
        att_dec9 = att9 - step9;
        att_inc9 = att9 + step9;

        if (press[B_PAUSE]) begin
            pause_d = ~pause_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (finish_ev || press[B_NEXT]) begin
                    sel_d  = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
                    change = 1'b1;
                end else if (press[B_PREV]) begin
                    sel_d  = (sel_q == 3'd0) ? SEL_LAST : sel_q - 3'd1;
                    change = 1'b1;
                end
                // A song change overrides a coincident pause toggle.
                if (change) begin
                    pause_d       = 1'b0;
                    song_change_d = 1'b1;
                    hold_cnt_d    = '0;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Opposing volume presses in one cycle cancel out.
        if (press[B_UP] && !press[B_DOWN]) begin
            att_d = (att9 < step9) ? 8'h00 : att_dec9[7:0];
        end else if (press[B_DOWN] && !press[B_UP]) begin
            att_d = (att9 > dn_lim9) ? VOL_MAX_ATT : att_inc9[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            deb_prev_q    <= '0;
            db_cnt_q      <= '0;
            fin_prev_q    <= 1'b0;
            state_q       <= ST_IDLE;
            hold_cnt_q    <= '0;
            sel_q         <= 3'd0;
            pause_q       <= 1'b0;
            att_q         <= VOL_INIT;
            song_change_q <= 1'b0;
        end else begin
            sync1_q       <= raw_in;
            sync2_q       <= sync1_q;
            deb_q         <= deb_d;
            deb_prev_q    <= deb_q;
            db_cnt_q      <= db_cnt_d;
            fin_prev_q    <= sync2_q[B_FIN];
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            sel_q         <= sel_d;
            pause_q       <= pause_d;
            att_q         <= att_d;
            song_change_q <= song_change_d;
        end
    end

    assign bus.o_song_select = sel_q;
    assign bus.o_pause       = pause_q;
    assign bus.o_vol         = {att_q, att_q};
    assign bus.o_busy        = (state_q == ST_HOLD);
    assign bus.o_song_change = song_change_q;

endmodule
